// File: rtl/point_to_affine_if.sv
// Request/response bundle for point_to_affine: operands in, affine result and status out.
interface point_to_affine_if;
   logic         i_start;
   logic [254:0] i_x;
   logic [254:0] i_y;
   logic [254:0] i_z;
   logic [254:0] o_x;
   logic [254:0] o_y;
   logic [255:0] o_enc;
   logic         o_busy;
   logic         o_valid;
   logic         o_error;

   modport master (
      output i_start, i_x, i_y, i_z,
      input  o_x, o_y, o_enc, o_busy, o_valid, o_error
   );

   modport slave (
      input  i_start, i_x, i_y, i_z,
      output o_x, o_y, o_enc, o_busy, o_valid, o_error
   );
endinterface

// File: rtl/numberMul.sv
// Montgomery multiplier mod 2^255-19 with R = 2^255: result = a*b*R^-1 mod p,
// o_finished pulses L cycles after i_start. Operands must be < p.
module numberMul #(
   parameter int unsigned L = 1
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_start,
   input  logic [254:0] i_a,
   input  logic [254:0] i_b,
   output logic [254:0] o_result,
   output logic         o_finished
);

   localparam logic [254:0] MODULUS = 255'((256'd1 << 255) - 256'd19);

   logic [254:0] res_q;
   logic [L-1:0] pipe_q;

   // Radix-2 interleaved reduction; u stays below 2p, so u + b + p fits in 257 bits.
   function automatic logic [254:0] mont_mul(input logic [254:0] a, input logic [254:0] b);
      logic [256:0] u;
      u = '0;
      for (int i = 0; i < 255; i++) begin
         if (a[i]) u = u + {2'b00, b};
         if (u[0]) u = u + {2'b00, MODULUS};
         u = u >> 1;
      end
      if (u >= {2'b00, MODULUS}) u = u - {2'b00, MODULUS};
      return u[254:0];
   endfunction

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         res_q  <= '0;
         pipe_q <= '0;
      end else begin
         pipe_q <= (pipe_q << 1) | L'(i_start);
         if (i_start) res_q <= mont_mul(i_a, i_b);
      end
   end

   assign o_result   = res_q;
   assign o_finished = pipe_q[L-1];

endmodule

// File: rtl/point_to_affine.sv
// Converts an extended Ed25519 point (Montgomery domain) to affine x, y and its encoding,
// inverting Z by Fermat exponentiation on a single shared Montgomery multiplier.
module point_to_affine #(
   parameter bit          P_ENC_SIGN = 1'b1,
   parameter int unsigned P_MUL_LAT  = 1
) (
   input logic              i_clk,
   input logic              i_rst,
   point_to_affine_if.slave bus
);

   localparam logic [254:0] MODULUS = 255'((256'd1 << 255) - 256'd19);
   localparam logic [254:0] INV_EXP = MODULUS - 255'd2;

   typedef enum logic [2:0] {StIdle, StInv, StMulX, StMulY, StExitX, StExitY, StDone} state_e;

   state_e       state_q, state_d;
   logic [254:0] acc_q, acc_d, x_q, x_d, y_q, y_d, z_q, z_d;
   logic [7:0]   idx_q, idx_d;
   logic         mpy_q, mpy_d;       // next INV operation is the multiply by Z
   logic         issued_q, issued_d; // product for the current step is in flight
   logic         zero_q, zero_d;
   logic [254:0] ox_q, ox_d, oy_q, oy_d;
   logic [255:0] oenc_q, oenc_d;
   logic         valid_q, valid_d, err_q, err_d;

   logic         mul_start, mul_done;
   logic [254:0] mul_a, mul_b, mul_res;
   logic         in_mul;

   numberMul #(
      .L (P_MUL_LAT)
   ) u_mul (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_start    (mul_start),
      .i_a        (mul_a),
      .i_b        (mul_b),
      .o_result   (mul_res),
      .o_finished (mul_done)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q  <= StIdle;
         acc_q    <= '0;
         x_q      <= '0;
         y_q      <= '0;
         z_q      <= '0;
         idx_q    <= '0;
         mpy_q    <= 1'b0;
         issued_q <= 1'b0;
         zero_q   <= 1'b0;
         ox_q     <= '0;
         oy_q     <= '0;
         oenc_q   <= '0;
         valid_q  <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         acc_q    <= acc_d;
         x_q      <= x_d;
         y_q      <= y_d;
         z_q      <= z_d;
         idx_q    <= idx_d;
         mpy_q    <= mpy_d;
         issued_q <= issued_d;
         zero_q   <= zero_d;
         ox_q     <= ox_d;
         oy_q     <= oy_d;
         oenc_q   <= oenc_d;
         valid_q  <= valid_d;
         err_q    <= err_d;
      end
   end

   assign in_mul = state_q inside {StInv, StMulX, StMulY, StExitX, StExitY};

   always_comb begin
      state_d   = state_q;
      acc_d     = acc_q;
      x_d       = x_q;
      y_d       = y_q;
      z_d       = z_q;
      idx_d     = idx_q;
      mpy_d     = mpy_q;
      issued_d  = issued_q;
      zero_d    = zero_q;
      ox_d      = ox_q;
      oy_d      = oy_q;
      oenc_d    = oenc_q;
      valid_d   = 1'b0;
      err_d     = err_q;
      mul_start = 1'b0;
      mul_a     = acc_q;
      mul_b     = acc_q;

      // Each product: one issue cycle, then wait for the multiplier's finish pulse.
      if (in_mul) begin
         mul_start = !issued_q;
         issued_d  = issued_q ? !mul_done : 1'b1;
      end

      unique case (state_q)
         StIdle: begin
            if (bus.i_start) begin
               zero_d   = (bus.i_z == '0);
               x_d      = bus.i_x;
               y_d      = bus.i_y;
               z_d      = bus.i_z;
               acc_d    = bus.i_z;
               idx_d    = 8'd253;
               mpy_d    = 1'b0;
               issued_d = 1'b0;
               err_d    = 1'b0;
               state_d  = zero_d ? StDone : StInv;
            end
         end
         StInv: begin
            mul_b = mpy_q ? z_q : acc_q;
            if (issued_q && mul_done) begin
               acc_d = mul_res;
               if (!mpy_q && INV_EXP[idx_q]) begin
                  mpy_d = 1'b1;
               end else begin
                  mpy_d = 1'b0;
                  if (idx_q == 8'd0) state_d = StMulX;
                  else               idx_d   = idx_q - 8'd1;
               end
            end
         end
         StMulX: begin
            mul_a = x_q;
            if (issued_q && mul_done) begin
               x_d     = mul_res;
               state_d = StMulY;
            end
         end
         StMulY: begin
            mul_a = y_q;
            if (issued_q && mul_done) begin
               y_d     = mul_res;
               state_d = StExitX;
            end
         end
         StExitX: begin
            mul_a = x_q;
            mul_b = 255'd1;
            if (issued_q && mul_done) begin
               x_d     = mul_res;
               state_d = StExitY;
            end
         end
         StExitY: begin
            mul_a = y_q;
            mul_b = 255'd1;
            if (issued_q && mul_done) begin
               y_d     = mul_res;
               state_d = StDone;
            end
         end
         StDone: begin
            ox_d    = zero_q ? '0 : x_q;
            oy_d    = zero_q ? '0 : y_q;
            oenc_d  = zero_q ? '0 : {P_ENC_SIGN & x_q[0], y_q};
            err_d   = zero_q;
            valid_d = 1'b1;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   assign bus.o_x     = ox_q;
   assign bus.o_y     = oy_q;
   assign bus.o_enc   = oenc_q;
   assign bus.o_busy  = (state_q != StIdle);
   assign bus.o_valid = valid_q;
   assign bus.o_error = err_q;

endmodule

// File: tb/tb_point_to_affine.sv
// Bench for point_to_affine: directed cases plus lockstep random lanes, scoreboard-checked.
module tb_point_to_affine;

   localparam int unsigned LAT     = 1;
   localparam int          JOB_LAT = 510 * (LAT + 1) + 2;
   localparam int          LIMIT   = JOB_LAT + 50;
   localparam int          NL      = 10;
   localparam logic [254:0] P      = 255'((256'd1 << 255) - 256'd19);

   typedef struct packed {
      logic [254:0] x;
      logic [254:0] y;
      logic [255:0] enc;
      logic         err;
   } res_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int   n_vec = 0;
   int   n_err = 0;
   res_t sb[$];
   res_t lane_sb[$];

   point_to_affine_if bus ();

   point_to_affine #(
      .P_ENC_SIGN (1'b1),
      .P_MUL_LAT  (LAT)
   ) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   // Parallel lanes keep 200 random points within a small cycle budget; upper half unsigned.
   logic         lane_start;
   logic [254:0] lx[NL], ly[NL], lz[NL], rx[NL], ry[NL];
   logic [255:0] renc[NL];
   logic         rvalid[NL], rerr[NL], rbusy[NL];

   for (genvar g = 0; g < NL; g++) begin : g_lane
      point_to_affine_if lif ();
      assign lif.i_start = lane_start;
      assign lif.i_x     = lx[g];
      assign lif.i_y     = ly[g];
      assign lif.i_z     = lz[g];
      assign rx[g]       = lif.o_x;
      assign ry[g]       = lif.o_y;
      assign renc[g]     = lif.o_enc;
      assign rvalid[g]   = lif.o_valid;
      assign rerr[g]     = lif.o_error;
      assign rbusy[g]    = lif.o_busy;
      point_to_affine #(
         .P_ENC_SIGN (g < NL / 2),
         .P_MUL_LAT  (LAT)
      ) u_lane (
         .i_clk (clk),
         .i_rst (rst),
         .bus   (lif)
      );
   end

   function automatic logic [254:0] mulmod(input logic [254:0] a, input logic [254:0] b);
      logic [509:0] t;
      t = 510'(a) * 510'(b);
      return 255'(t % 510'(P));
   endfunction

   function automatic logic [254:0] mont(input logic [254:0] a);
      logic [509:0] t;
      t = {a, 255'd0};
      return 255'(t % 510'(P));
   endfunction

   function automatic logic [254:0] rand_fe();
      logic [255:0] r;
      for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
      return 255'(r % 256'(P));
   endfunction

   function automatic res_t expect_pt(input logic [254:0] x, input logic [254:0] y,
                                      input bit sign);
      res_t e;
      e.x   = x;
      e.y   = y;
      e.enc = {sign & x[0], y};
      e.err = 1'b0;
      return e;
   endfunction

   task automatic pulse_start(input logic [254:0] x, input logic [254:0] y,
                              input logic [254:0] z);
      bus.i_x     = x;
      bus.i_y     = y;
      bus.i_z     = z;
      bus.i_start = 1'b1;
      @(posedge clk); #1;
      bus.i_start = 1'b0;
   endtask

   // Called in the cycle after the start edge; returns the start-to-valid latency.
   task automatic wait_valid(output int lat);
      lat = 1;
      while (bus.o_valid !== 1'b1 && lat < LIMIT) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      n_vec++;
      if ({bus.o_x, bus.o_y, bus.o_enc, bus.o_busy, bus.o_valid, bus.o_error} !== '0) begin
         n_err++;
         $display("FAIL reset_outputs: got x=%h y=%h enc=%h busy=%b valid=%b err=%b, want all 0",
                  bus.o_x, bus.o_y, bus.o_enc, bus.o_busy, bus.o_valid, bus.o_error);
      end
      rst = 1'b0;
      @(posedge clk); #1;
      n_vec++;
      if ({bus.o_busy, bus.o_valid} !== 2'b00) begin
         n_err++;
         $display("FAIL reset_release: got busy=%b valid=%b, want 0 0", bus.o_busy, bus.o_valid);
      end
   endtask

   task automatic run_and_check(input string name, input logic [254:0] xi, input logic [254:0] yi,
                                input logic [254:0] zi, input res_t exp_r, input int exp_lat);
      res_t e;
      int   lat;
      sb.push_back(exp_r);
      pulse_start(xi, yi, zi);
      n_vec++;
      if (bus.o_busy !== 1'b1) begin
         n_err++;
         $display("FAIL %s_busy: got %b, want 1", name, bus.o_busy);
      end
      wait_valid(lat);
      n_vec++;
      if (lat != exp_lat) begin
         n_err++;
         $display("FAIL %s_latency: got %0d, want %0d", name, lat, exp_lat);
      end
      e = sb.pop_front();
      n_vec++;
      if ({bus.o_x, bus.o_y, bus.o_enc, bus.o_error} !== e) begin
         n_err++;
         $display("FAIL %s_result: got x=%h y=%h enc=%h err=%b, want x=%h y=%h enc=%h err=%b",
                  name, bus.o_x, bus.o_y, bus.o_enc, bus.o_error, e.x, e.y, e.enc, e.err);
      end
   endtask

   task automatic test_basic();
      res_t e;
      e = expect_pt(255'd3, 255'd5, 1'b1);
      run_and_check("basic", mont(255'd6), mont(255'd10), mont(255'd2), e, JOB_LAT);
      @(posedge clk); #1;
      n_vec++;
      if ({bus.o_valid, bus.o_busy, bus.o_x, bus.o_y} !== {2'b00, 255'd3, 255'd5}) begin
         n_err++;
         $display("FAIL basic_hold: got valid=%b busy=%b x=%h y=%h, want 0 0 x=3 y=5",
                  bus.o_valid, bus.o_busy, bus.o_x, bus.o_y);
      end
   endtask

   task automatic test_neg_one();
      res_t e;
      e = expect_pt(P - 255'd1, 255'd0, 1'b1);
      run_and_check("neg_one", mont(255'd1), 255'd0, mont(P - 255'd1), e, JOB_LAT);
   endtask

   task automatic test_zero_z();
      res_t e;
      e     = '0;
      e.err = 1'b1;
      run_and_check("zero_z", mont(255'd7), mont(255'd9), 255'd0, e, 2);
      @(posedge clk); #1;
      n_vec++;
      if ({bus.o_busy, bus.o_valid, bus.o_error} !== 3'b001) begin
         n_err++;
         $display("FAIL zero_z_after: got busy=%b valid=%b err=%b, want 0 0 1",
                  bus.o_busy, bus.o_valid, bus.o_error);
      end
   endtask

   task automatic test_ignore_start();
      res_t e;
      int   lat;
      sb.push_back(expect_pt(255'd11, 255'd13, 1'b1));
      pulse_start(mont(255'd44), mont(255'd52), mont(255'd4));
      n_vec++;
      if (bus.o_error !== 1'b0) begin
         n_err++;
         $display("FAIL ignore_err_clear: got %b, want 0", bus.o_error);
      end
      repeat (99) begin @(posedge clk); #1; end
      pulse_start(mont(255'd1), mont(255'd2), mont(255'd1));
      wait_valid(lat);
      n_vec++;
      if (lat + 100 != JOB_LAT) begin
         n_err++;
         $display("FAIL ignore_latency: got %0d, want %0d", lat + 100, JOB_LAT);
      end
      e = sb.pop_front();
      n_vec++;
      if ({bus.o_x, bus.o_y, bus.o_enc, bus.o_error} !== e) begin
         n_err++;
         $display("FAIL ignore_result: got x=%h y=%h enc=%h err=%b, want x=%h y=%h enc=%h err=%b",
                  bus.o_x, bus.o_y, bus.o_enc, bus.o_error, e.x, e.y, e.enc, e.err);
      end
   endtask

   task automatic test_abort();
      int seen;
      seen = 0;
      pulse_start(mont(255'd5), mont(255'd6), mont(255'd3));
      repeat (999) begin
         @(posedge clk); #1;
         if (bus.o_valid === 1'b1) seen++;
      end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      n_vec++;
      if ({bus.o_x, bus.o_y, bus.o_enc, bus.o_busy, bus.o_valid, bus.o_error} !== '0) begin
         n_err++;
         $display("FAIL abort_outputs: got x=%h y=%h enc=%h busy=%b valid=%b err=%b, want all 0",
                  bus.o_x, bus.o_y, bus.o_enc, bus.o_busy, bus.o_valid, bus.o_error);
      end
      repeat (40) begin
         @(posedge clk); #1;
         if (bus.o_valid === 1'b1) seen++;
      end
      n_vec++;
      if (seen != 0) begin
         n_err++;
         $display("FAIL abort_no_valid: got %0d valid pulses, want 0", seen);
      end
      run_and_check("after_abort", mont(mulmod(255'd9, 255'd5)), mont(mulmod(255'd2, 255'd5)),
                    mont(255'd5), expect_pt(255'd9, 255'd2, 1'b1), JOB_LAT);
   endtask

   task automatic test_back_to_back();
      res_t e;
      int   lat;
      logic [254:0] za, zb;
      za = 255'd7;
      zb = P - 255'd3;
      sb.push_back(expect_pt(P - 255'd2, 255'd1, 1'b1));
      pulse_start(mont(mulmod(P - 255'd2, za)), mont(za), mont(za));
      repeat (JOB_LAT - 2) begin @(posedge clk); #1; end
      n_vec++;
      if ({bus.o_busy, bus.o_valid} !== 2'b10) begin
         n_err++;
         $display("FAIL b2b_done_cycle: got busy=%b valid=%b, want 1 0", bus.o_busy, bus.o_valid);
      end
      // Start held across the DONE cycle and the following IDLE cycle.
      bus.i_x     = mont(mulmod(255'd17, zb));
      bus.i_y     = mont(mulmod(P - 255'd5, zb));
      bus.i_z     = mont(zb);
      bus.i_start = 1'b1;
      sb.push_back(expect_pt(255'd17, P - 255'd5, 1'b1));
      @(posedge clk); #1;
      e = sb.pop_front();
      n_vec++;
      if ({bus.o_valid, bus.o_x, bus.o_y, bus.o_enc, bus.o_error} !== {1'b1, e}) begin
         n_err++;
         $display("FAIL b2b_first: got valid=%b x=%h y=%h enc=%h err=%b, want 1 x=%h y=%h enc=%h",
                  bus.o_valid, bus.o_x, bus.o_y, bus.o_enc, bus.o_error, e.x, e.y, e.enc);
      end
      @(posedge clk); #1;
      bus.i_start = 1'b0;
      wait_valid(lat);
      n_vec++;
      if (lat != JOB_LAT) begin
         n_err++;
         $display("FAIL b2b_latency: got %0d, want %0d", lat, JOB_LAT);
      end
      e = sb.pop_front();
      n_vec++;
      if ({bus.o_x, bus.o_y, bus.o_enc, bus.o_error} !== e) begin
         n_err++;
         $display("FAIL b2b_second: got x=%h y=%h enc=%h err=%b, want x=%h y=%h enc=%h err=%b",
                  bus.o_x, bus.o_y, bus.o_enc, bus.o_error, e.x, e.y, e.enc, e.err);
      end
   endtask

   task automatic test_random();
      res_t         e;
      int           lat;
      logic [254:0] x, y, z;
      for (int r = 0; r < 200 / NL; r++) begin
         for (int i = 0; i < NL; i++) begin
            x = rand_fe();
            y = rand_fe();
            do z = rand_fe(); while (z == '0);
            lx[i] = mont(mulmod(x, z));
            ly[i] = mont(mulmod(y, z));
            lz[i] = mont(z);
            lane_sb.push_back(expect_pt(x, y, i < NL / 2));
         end
         lane_start = 1'b1;
         @(posedge clk); #1;
         lane_start = 1'b0;
         lat = 1;
         while (rvalid[0] !== 1'b1 && lat < LIMIT) begin
            @(posedge clk); #1;
            lat++;
         end
         n_vec++;
         if (lat != JOB_LAT) begin
            n_err++;
            $display("FAIL rand_latency: round %0d got %0d, want %0d", r, lat, JOB_LAT);
         end
         for (int i = 0; i < NL; i++) begin
            e = lane_sb.pop_front();
            n_vec++;
            if ({rx[i], ry[i], renc[i], rerr[i], rvalid[i], rbusy[i]} !== {e, 2'b10}) begin
               n_err++;
               $display("FAIL rand_point: lane %0d got x=%h y=%h enc=%h e/v/b=%b%b%b, want x=%h y=%h enc=%h",
                        i, rx[i], ry[i], renc[i], rerr[i], rvalid[i], rbusy[i], e.x, e.y, e.enc);
            end
         end
      end
   endtask

   initial begin
      rst         = 1'b1;
      bus.i_start = 1'b0;
      bus.i_x     = '0;
      bus.i_y     = '0;
      bus.i_z     = '0;
      lane_start  = 1'b0;
      for (int i = 0; i < NL; i++) begin
         lx[i] = '0;
         ly[i] = '0;
         lz[i] = '0;
      end
      test_reset();
      test_basic();
      test_neg_one();
      test_zero_z();
      test_ignore_start();
      test_abort();
      test_back_to_back();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/point_to_affine.md
POINT_TO_AFFINE -- requirements
Module: point_to_affine

Interface
REQ-001 SHALL have parameter P_ENC_SIGN, default 1, meaning 1 places x parity in o_enc[255] and 0 forces o_enc[255]=0.
REQ-002 SHALL have port i_clk, input, 1 bit: clock; all state updates on its rising edge.
REQ-003 SHALL have port i_rst, input, 1 bit: reset, synchronous, active-high.
REQ-004 SHALL have port i_start, input, 1 bit: one-cycle request pulse, sampled only in IDLE.
REQ-005 SHALL have ports i_x, i_y, i_z, inputs, 255 bits each: extended-coordinate X, Y, Z, Montgomery domain, each < p = 2^255-19.
REQ-006 SHALL have ports o_x and o_y, outputs, 255 bits each: affine x = X/Z and y = Y/Z mod p, normal domain.
REQ-007 SHALL have port o_enc, output, 256 bits: point encoding {x[0], y}.
REQ-008 SHALL have port o_busy, output, 1 bit: high in every state except IDLE.
REQ-009 SHALL have port o_valid, output, 1 bit: one-cycle pulse when outputs update.
REQ-010 SHALL have port o_error, output, 1 bit: held high with o_valid when Z = 0.

Function
REQ-011 SHALL use exactly one numberMul instance (Montgomery product a*b*R^-1 mod p, i_start pulse, o_finished pulse after latency L) driven by the same i_clk and i_rst.
REQ-012 SHALL implement states IDLE, INV, MULX, MULY, EXITX, EXITY, DONE.
REQ-013 IDLE with i_start=1 SHALL latch i_x, i_y and i_z, and clear o_error.
REQ-014 On that start, if i_z = 0, SHALL go to DONE with o_x = o_y = 0 and o_error = 1.
REQ-015 On that start, if i_z != 0, SHALL go to INV with acc = Z and the bit index at 253.
REQ-016 INV SHALL compute Z^(p-2) by left-to-right square-and-multiply over exponent bits 253..0, exponent p-2 = 2^255-21.
REQ-017 For each bit, INV SHALL square acc, then multiply acc by Z if the bit is 1: 254 squarings and 252 multiplies.
REQ-018 Each product SHALL take 1 start cycle plus L cycles; acc updates in the cycle numberMul o_finished is high.
REQ-019 INV SHALL exit to MULX after the last operation at bit 0.
REQ-020 MULX SHALL compute X*acc; MULY SHALL compute Y*acc.
REQ-021 EXITX and EXITY SHALL multiply the MULX and MULY results by 1, leaving the Montgomery domain.
REQ-022 DONE SHALL register o_x, o_y and o_enc, pulse o_valid for one cycle, and return to IDLE on the next cycle.
REQ-023 Total latency from i_start to o_valid SHALL be 510*(L+1)+2 cycles for Z != 0 and 2 cycles for Z = 0.
REQ-024 i_start while o_busy=1 SHALL be ignored, with no effect on latched operands or results.
REQ-025 o_x, o_y, o_enc and o_error SHALL hold their last values until the next DONE.
REQ-026 i_start on the cycle DONE returns to IDLE SHALL be accepted on the following cycle, when the FSM is in IDLE.
REQ-027 All additions inside the block SHALL be width-safe, and results SHALL be fully reduced to < p.

Reset
REQ-028 i_rst=1 SHALL force IDLE and set o_x, o_y, o_enc, o_busy, o_valid, o_error, acc and the bit index to 0.
REQ-029 Reset mid-operation SHALL abort with no o_valid, and any in-flight numberMul result SHALL be discarded.
REQ-030 The first i_start after i_rst deasserts SHALL be accepted normally.

Verification
REQ-031 Bench SHALL cover X=mont(6), Y=mont(10), Z=mont(2) -> o_x=3, o_y=5, o_enc={1,255'd5}, o_error=0, latency per REQ-023.
REQ-032 Bench SHALL cover X=mont(1), Y=0, Z=mont(p-1) -> o_x=p-1, o_y=0, o_enc[255]=0.
REQ-033 Bench SHALL cover i_z=0 -> o_valid and o_error high 2 cycles after start, o_x=o_y=0, o_busy low afterwards.
REQ-034 Bench SHALL cover a second i_start with different operands at cycle 100 of a running job -> ignored; first result unchanged.
REQ-035 Bench SHALL cover i_rst at cycle 1000 of INV -> no o_valid, outputs 0; a fresh job then completes correctly.
REQ-036 Bench SHALL cover 200 random valid points against a golden model, including P_ENC_SIGN=0 -> o_enc[255]=0 always.
